rgb_to_gray: RTL

- AXI-Stream preprocessing stage directly upstream of the 8-bit Gaussian filter.
- Converts a W×H frame of 24-bit RGB pixels to 8-bit luma: Y = (77R + 150G + 29B + 128) >> 8.
- Checks frame length against TLAST and regenerates a clean TLAST on the output.
- Fully backpressure-aware, since the downstream filter can drop tready at any time.
- Uses the same start/status/err_code control scheme as the filter.

---
 rtl/rgb_to_gray.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rgb_to_gray.sv
// rtl/rgb_to_gray.sv - AXI-Stream RGB888 to 8-bit luma converter with frame length checking
module rgb_to_gray #(
    parameter int W           = 64,
    parameter int H           = 64,
    parameter int TOTAL_PIXEL = W * H,
    parameter int CNT_BIT     = $clog2(W * H) + 1,
    parameter int TIME_LIMIT  = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [1:0]  status,
    output logic [1:0]  err_code,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [1:0] E_NONE    = 2'd0;
    localparam logic [1:0] E_TIMEOUT = 2'd1;
    localparam logic [1:0] E_EARLY   = 2'd2;
    localparam logic [1:0] E_LATE    = 2'd3;

    localparam int WD_BIT = $clog2(TIME_LIMIT + 1) + 1;
    localparam logic [WD_BIT-1:0]  WD_LIMIT  = WD_BIT'(TIME_LIMIT);
    localparam logic [CNT_BIT-1:0] TOTAL_CNT = CNT_BIT'(TOTAL_PIXEL);
    localparam logic [CNT_BIT-1:0] LAST_IDX  = CNT_BIT'(TOTAL_PIXEL - 1);

    logic [1:0]         state, state_nxt, err_nxt;
    logic [CNT_BIT-1:0] in_cnt;
    logic [WD_BIT-1:0]  wd_cnt;
    logic               en, in_fire, out_fire, in_is_last, wd_expired, flush;

    logic        s1_valid, s1_last;
    logic [15:0] s1_pr, s1_pg, s1_pb;
    logic        s2_valid, s2_last;
    logic [16:0] s2_sum;

    always_comb begin
        en            = !m_axis_tvalid || m_axis_tready;
        // Once the full frame has been accepted, input stays closed while the pipe drains
        s_axis_tready = en && (state == S_BUSY) && (in_cnt < TOTAL_CNT);
        in_fire       = s_axis_tvalid && s_axis_tready;
        out_fire      = m_axis_tvalid && m_axis_tready;
        in_is_last    = (in_cnt == LAST_IDX);
        wd_expired    = !in_fire && !out_fire && (wd_cnt >= WD_LIMIT);
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        case (state)
            S_IDLE: begin
                err_nxt = E_NONE;
                if (start) state_nxt = S_BUSY;
            end
            S_BUSY: begin
                // Errors are checked first so they win over a same-cycle frame completion
                if (in_fire && s_axis_tlast && !in_is_last) begin
                    state_nxt = S_ERROR;
                    err_nxt   = E_EARLY;
                end else if (in_fire && !s_axis_tlast && in_is_last) begin
                    state_nxt = S_ERROR;
                    err_nxt   = E_LATE;
                end else if (wd_expired) begin
                    state_nxt = S_ERROR;
                    err_nxt   = E_TIMEOUT;
                end else if (out_fire && m_axis_tlast) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                if (!start) state_nxt = S_IDLE;
            end
        endcase
        flush = (state_nxt != S_BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            status   <= S_IDLE;
            err_code <= E_NONE;
            in_cnt   <= '0;
            wd_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            status   <= state;
            err_code <= err_nxt;
            if (state != S_BUSY) begin
                in_cnt <= '0;
                wd_cnt <= '0;
            end else begin
                if (in_fire) in_cnt <= in_cnt + CNT_BIT'(1);
                if (in_fire || out_fire)   wd_cnt <= '0;
                else if (wd_cnt < WD_LIMIT) wd_cnt <= wd_cnt + WD_BIT'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_pr         <= '0;
            s1_pg         <= '0;
            s1_pb         <= '0;
            s2_valid      <= 1'b0;
            s2_last       <= 1'b0;
            s2_sum        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (flush) begin
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_last       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (en) begin
            s1_valid      <= in_fire;
            s1_last       <= in_fire && in_is_last;
            s1_pr         <= 16'd77  * 16'(s_axis_tdata[23:16]);
            s1_pg         <= 16'd150 * 16'(s_axis_tdata[15:8]);
            s1_pb         <= 16'd29  * 16'(s_axis_tdata[7:0]);
            s2_valid      <= s1_valid;
            s2_last       <= s1_last;
            s2_sum        <= 17'(s1_pr) + 17'(s1_pg) + 17'(s1_pb) + 17'd128;
            m_axis_tvalid <= s2_valid;
            m_axis_tlast  <= s2_last;
            // Coefficients sum to 256, so the rounded result never exceeds 255
            m_axis_tdata  <= 8'(s2_sum >> 8);
        end
    end

endmodule
